// File: rtl/cell_pkg.sv
// Shared cell-link definitions used by both the transmitter and the receive checker.
// No logic, so no latency and no backpressure.
// Holds the FSM state encoding, the default payload pattern and the beat-count helper.
package cell_pkg;

    typedef enum logic {
        CELL_IDLE = 1'b0,
        CELL_RECV = 1'b1
    } cell_state_t;

    localparam int          CELL_BYTES       = 53;
    localparam logic [31:0] PAY_INIT_DEFAULT = 32'h01020304;
    localparam logic [31:0] PAY_INC_DEFAULT  = 32'h01010101;

    // Number of beats needed to carry one cell; a partial final beat counts as a beat.
    function automatic int cell_transfers(input int cell_size, input int dat_width);
        return cell_size / dat_width + (((cell_size % dat_width) != 0) ? 1 : 0);
    endfunction

endpackage

// File: rtl/cell_pattern_gen.sv
// Deterministic payload generator: beat k carries init + k*inc, modulo 2^DAT_WIDTH.
// exp is combinational from load (beat 0 seen in the same cycle), registered afterwards.
// No backpressure: the owner advances it with load/step on each accepted beat.
module cell_pattern_gen
    import cell_pkg::*;
#(
    parameter int          DAT_WIDTH = 32,
    parameter logic [31:0] PAY_INIT  = PAY_INIT_DEFAULT,
    parameter logic [31:0] PAY_INC   = PAY_INC_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    output logic [DAT_WIDTH-1:0] exp
);

    localparam logic [63:0]          INIT64 = 64'(PAY_INIT);
    localparam logic [63:0]          INC64  = 64'(PAY_INC);
    localparam logic [DAT_WIDTH-1:0] INIT_W = INIT64[DAT_WIDTH-1:0];
    localparam logic [DAT_WIDTH-1:0] INC_W  = INC64[DAT_WIDTH-1:0];

    logic [DAT_WIDTH-1:0] exp_q;

    // load wins so a new cell always restarts the sequence, even mid-cell.
    assign exp = load ? INIT_W : exp_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q <= INIT_W;
        end else if (load) begin
            exp_q <= INIT_W + INC_W;
        end else if (step) begin
            exp_q <= exp_q + INC_W;
        end
    end

endmodule

// File: rtl/cell_word_rx.sv
// Receive checker for the cell word stream; pulses cell_done/cell_err per cell (CELL_WORD_RX_STATS_EN adds counters).
// Pulses and counters appear one cycle after the edge that accepts the last or aborting beat.
// No backpressure: every valid beat is consumed; non-sop beats outside a cell are dropped.
module cell_word_rx
    import cell_pkg::*;
#(
    parameter int          DAT_WIDTH = 32,
    parameter int          CELL_SIZE = CELL_BYTES * 8,
    parameter logic [31:0] PAY_INIT  = PAY_INIT_DEFAULT,
    parameter logic [31:0] PAY_INC   = PAY_INC_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dat_valid,
    input  logic                 sop,
    input  logic [DAT_WIDTH-1:0] dat,
    output logic                 busy,
    output logic                 cell_done,
    output logic                 cell_err,
    output logic [15:0]          cell_cnt,
    output logic [15:0]          err_cnt
);

    localparam int TRANSFERS = cell_transfers(CELL_SIZE, DAT_WIDTH);
    localparam int CNT_W     = (TRANSFERS > 1) ? $clog2(TRANSFERS) : 1;
    localparam int LAST_BITS = ((CELL_SIZE % DAT_WIDTH) == 0) ? DAT_WIDTH : (CELL_SIZE % DAT_WIDTH);
    localparam logic [DAT_WIDTH-1:0] LAST_MASK = {DAT_WIDTH{1'b1}} >> (DAT_WIDTH - LAST_BITS);
    localparam logic [CNT_W-1:0]     LAST_IDX  = CNT_W'(TRANSFERS - 1);

    cell_state_t          state;
    logic [CNT_W-1:0]     beat_cnt;
    logic                 mism_q;
    logic [DAT_WIDTH-1:0] exp;

    logic start, beat, abort, last_beat, mism, mism_acc, fin_ok, fin_bad;
    logic [DAT_WIDTH-1:0] cmp_mask;

    // A sop beat always starts a cell, whether in IDLE or as a runt restart in RECV.
    assign start     = dat_valid && sop;
    assign beat      = dat_valid && !sop && (state == CELL_RECV);
    assign abort     = start && (state == CELL_RECV);
    assign last_beat = (beat && (beat_cnt == LAST_IDX)) || (start && (TRANSFERS == 1));
    assign cmp_mask  = last_beat ? LAST_MASK : {DAT_WIDTH{1'b1}};
    assign mism      = ((dat ^ exp) & cmp_mask) != '0;
    assign mism_acc  = mism || (beat && mism_q);
    assign fin_ok    = last_beat && !mism_acc;
    assign fin_bad   = abort || (last_beat && mism_acc);

    cell_pattern_gen #(
        .DAT_WIDTH (DAT_WIDTH),
        .PAY_INIT  (PAY_INIT),
        .PAY_INC   (PAY_INC)
    ) u_pattern (
        .clk  (clk),
        .rst  (rst),
        .load (start),
        .step (beat),
        .exp  (exp)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= CELL_IDLE;
            busy      <= 1'b0;
            beat_cnt  <= '0;
            mism_q    <= 1'b0;
            cell_done <= 1'b0;
            cell_err  <= 1'b0;
        end else begin
            cell_done <= fin_ok;
            cell_err  <= fin_bad;
            if (start) begin
                if (TRANSFERS == 1) begin
                    state    <= CELL_IDLE;
                    busy     <= 1'b0;
                    beat_cnt <= '0;
                    mism_q   <= 1'b0;
                end else begin
                    state    <= CELL_RECV;
                    busy     <= 1'b1;
                    beat_cnt <= CNT_W'(1);
                    mism_q   <= mism;
                end
            end else if (beat) begin
                if (last_beat) begin
                    state    <= CELL_IDLE;
                    busy     <= 1'b0;
                    beat_cnt <= '0;
                    mism_q   <= 1'b0;
                end else begin
                    beat_cnt <= beat_cnt + CNT_W'(1);
                    mism_q   <= mism_acc;
                end
            end
        end
    end

`ifdef CELL_WORD_RX_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cell_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            if ((fin_ok || fin_bad) && (cell_cnt != 16'hFFFF)) begin
                cell_cnt <= cell_cnt + 16'd1;
            end
            if (fin_bad && (err_cnt != 16'hFFFF)) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end
`else
    assign cell_cnt = '0;
    assign err_cnt  = '0;
`endif

endmodule
